// File: rtl/burst_packer.sv
// Packs a single-pixel AXI-Stream into PIXELS_PER_BURST-wide bursts, frame-aligned on SOF,
// with first/last-burst flags, row/column tracking and a mid-frame SOF error pulse.
module burst_packer #(
  parameter int PIXEL_BIT_WIDTH  = 10,
  parameter int PIXELS_PER_BURST = 10,
  parameter int USER_WIDTH       = 2,
  parameter int ROWS             = 20,
  parameter int COLS             = 20
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      s_axis_tvalid,
  output logic                                      s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0]                s_axis_tdata,
  input  logic [USER_WIDTH-1:0]                     s_axis_tuser,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic [PIXEL_BIT_WIDTH*PIXELS_PER_BURST-1:0] m_axis_tdata,
  output logic [USER_WIDTH-1:0]                     m_axis_tuser,
  output logic                                      m_axis_tlast,
  output logic [$clog2(COLS)-1:0]                   cnt_col,
  output logic [$clog2(ROWS)-1:0]                   cnt_row,
  output logic                                      sof_error
);

  localparam int BW    = PIXEL_BIT_WIDTH * PIXELS_PER_BURST;
  localparam int TOTAL = ROWS * COLS;
  localparam int LW    = (PIXELS_PER_BURST > 1) ? $clog2(PIXELS_PER_BURST) : 1;
  localparam int PW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);

  localparam logic [LW-1:0] LANE_LAST  = LW'(PIXELS_PER_BURST - 1);
  localparam logic [PW-1:0] PIX_LAST   = PW'(TOTAL - 1);
  localparam logic [PW-1:0] FIRST_DONE = PW'(PIXELS_PER_BURST - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

  typedef enum logic {WAIT_SOF, PACK} state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic [PW-1:0]        pix_q, pix_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [BW-1:0]        asm_q, asm_d;
  logic                 mvalid_q, mvalid_d;
  logic [BW-1:0]        mdata_q, mdata_d;
  logic [USER_WIDTH-1:0] muser_q, muser_d;
  logic                 soferr_q, soferr_d;

  logic                 out_free, ready, sof, hs, take, complete, last_pix;
  logic [LW-1:0]        lane_idx;
  logic [PW-1:0]        pix_idx;
  logic [CW-1:0]        col_base;
  logic [RW-1:0]        row_base;
  logic [BW-1:0]        merged;

  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser[USER_WIDTH-1:1];

  // A SOF pixel always restarts lane and position at zero, whether it opens a frame or aborts one.
  always_comb begin
    out_free = !mvalid_q || m_axis_tready;
    sof      = s_axis_tuser[0];
    ready    = 1'b0;
    if (!reset) begin
      if (state_q == WAIT_SOF) ready = (PIXELS_PER_BURST > 1) || out_free;
      else                     ready = (lane_q != LANE_LAST) || out_free;
    end
    hs       = s_axis_tvalid && ready;
    take     = hs && (sof || state_q == PACK);
    lane_idx = sof ? '0 : lane_q;
    pix_idx  = sof ? '0 : pix_q;
    col_base = sof ? '0 : col_q;
    row_base = sof ? '0 : row_q;
    merged   = asm_q;
    merged[lane_idx*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] = s_axis_tdata;
    complete = take && (lane_idx == LANE_LAST);
    last_pix = take && (pix_idx == PIX_LAST);
  end

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    pix_d    = pix_q;
    col_d    = col_q;
    row_d    = row_q;
    asm_d    = asm_q;
    mvalid_d = mvalid_q;
    mdata_d  = mdata_q;
    muser_d  = muser_q;
    soferr_d = 1'b0;

    if (mvalid_q && m_axis_tready) mvalid_d = 1'b0;

    if (take) begin
      asm_d    = merged;
      lane_d   = complete ? '0 : lane_idx + 1'b1;
      soferr_d = sof && (state_q == PACK) && (pix_q != '0);
      if (last_pix) begin
        pix_d   = '0;
        col_d   = '0;
        row_d   = '0;
        state_d = WAIT_SOF;
      end else begin
        pix_d   = pix_idx + 1'b1;
        state_d = PACK;
        if (col_base == COL_LAST) begin
          col_d = '0;
          row_d = row_base + 1'b1;
        end else begin
          col_d = col_base + 1'b1;
          row_d = row_base;
        end
      end
      // Loading on the same edge as a drain gives back-to-back bursts.
      if (complete) begin
        mvalid_d   = 1'b1;
        mdata_d    = merged;
        muser_d    = '0;
        muser_d[0] = (pix_idx == FIRST_DONE);
        muser_d[1] = last_pix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WAIT_SOF;
      lane_q   <= '0;
      pix_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      asm_q    <= '0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
      muser_q  <= '0;
      soferr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      pix_q    <= pix_d;
      col_q    <= col_d;
      row_q    <= row_d;
      asm_q    <= asm_d;
      mvalid_q <= mvalid_d;
      mdata_q  <= mdata_d;
      muser_q  <= muser_d;
      soferr_q <= soferr_d;
    end
  end

  assign s_axis_tready = ready;
  assign m_axis_tvalid = mvalid_q;
  assign m_axis_tdata  = mdata_q;
  assign m_axis_tuser  = muser_q;
  assign m_axis_tlast  = muser_q[1];
  assign cnt_col       = col_q;
  assign cnt_row       = row_q;
  assign sof_error     = soferr_q;

endmodule

// File: tb/tb_burst_packer.sv
// Scoreboard bench for burst_packer: a frame-level model queues expected bursts as pixels
// are accepted; a monitor pops and compares them as the DUT hands them off.
module tb_burst_packer;

  localparam int W     = 10;
  localparam int PPB   = 10;
  localparam int UW    = 2;
  localparam int ROWS  = 20;
  localparam int COLS  = 20;
  localparam int BW    = W * PPB;
  localparam int TOTAL = ROWS * COLS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [W-1:0]  s_axis_tdata = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [BW-1:0] m_axis_tdata;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tlast;
  logic [$clog2(COLS)-1:0] cnt_col;
  logic [$clog2(ROWS)-1:0] cnt_row;
  logic          sof_error;

  burst_packer #(
    .PIXEL_BIT_WIDTH(W), .PIXELS_PER_BURST(PPB), .USER_WIDTH(UW), .ROWS(ROWS), .COLS(COLS)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .cnt_col(cnt_col), .cnt_row(cnt_row), .sof_error(sof_error)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] data;
    logic [1:0]    user;
  } burst_t;

  int vectors = 0;
  int miscompares = 0;
  int bursts_rx = 0;
  int sof_err_seen = 0;
  int blocked_cycles = 0;
  int stall_cycles = 0;
  bit rand_ready = 0;

  burst_t       exp_q[$];
  logic [W-1:0] mbuf[$];
  int           mpos = 0;
  int           mburst = 0;
  bit           minframe = 0;

  // Frame-level reference: collect pixels of the current frame and emit every PPB of them.
  function automatic void model_accept(logic [W-1:0] d, logic sof);
    burst_t b;
    if (!minframe && !sof) return;
    if (sof) begin
      mbuf.delete();
      mpos = 0;
      mburst = 0;
      minframe = 1;
    end
    mbuf.push_back(d);
    mpos++;
    if (mbuf.size() == PPB) begin
      for (int k = 0; k < PPB; k++) b.data[k*W +: W] = mbuf[k];
      b.user[0] = (mburst == 0);
      b.user[1] = (mpos == TOTAL);
      exp_q.push_back(b);
      mbuf.delete();
      mburst++;
    end
    if (mpos == TOTAL) begin
      minframe = 0;
      mpos = 0;
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    mbuf.delete();
    mpos = 0;
    mburst = 0;
    minframe = 0;
  endfunction

  // Downstream ready: forced-low stall window, random back-pressure, or always ready.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (stall_cycles > 0) begin
        m_axis_tready = 1'b0;
        stall_cycles--;
      end else if (rand_ready) m_axis_tready = ($urandom_range(0, 9) >= 3);
      else m_axis_tready = 1'b1;
    end
  end

  // Monitor: pops on each output handshake and checks that stalled bursts hold steady.
  initial begin
    burst_t e;
    bit held_active;
    logic [BW-1:0] held_data;
    logic [UW-1:0] held_user;
    held_active = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_active = 0;
      end else begin
        if (sof_error) sof_err_seen++;
        if (held_active) begin
          vectors++;
          if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held_data || m_axis_tuser !== held_user) begin
            miscompares++;
            $display("[TB] FAIL hold_stable: valid=%0b data=%h user=%b, required valid=1 data=%h user=%b",
                     m_axis_tvalid, m_axis_tdata, m_axis_tuser, held_data, held_user);
          end
        end
        held_active = m_axis_tvalid && !m_axis_tready;
        held_data = m_axis_tdata;
        held_user = m_axis_tuser;
        if (m_axis_tvalid && m_axis_tready) begin
          bursts_rx++;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_burst: data=%h user=%b, required no burst", m_axis_tdata, m_axis_tuser);
          end else begin
            e = exp_q.pop_front();
            if (m_axis_tdata !== e.data || m_axis_tuser !== e.user || m_axis_tlast !== e.user[1]) begin
              miscompares++;
              $display("[TB] FAIL burst: data=%h user=%b last=%b, required data=%h user=%b last=%b",
                       m_axis_tdata, m_axis_tuser, m_axis_tlast, e.data, e.user, e.user[1]);
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send_pixel(input logic [W-1:0] d, input logic sof);
    bit acc;
    int waitc;
    acc = 0;
    waitc = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = d;
    s_axis_tuser = {1'b0, sof};
    while (!acc) begin
      @(negedge clk);
      if (s_axis_tready) begin
        model_accept(d, sof);
        acc = 1;
      end else begin
        blocked_cycles++;
        waitc++;
        if (waitc > 2000) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL input_timeout: tready=%0b, required 1 within 2000 cycles", s_axis_tready);
          acc = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser = '0;
  endtask

  task automatic send_range(input int start, input int n, input bit sof_first, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          @(posedge clk);
          #1;
        end
      end
      send_pixel(W'((start + i) % 1024), sof_first && (i == 0));
    end
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(negedge clk);
    @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_drain: %0d bursts outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic check_counts(input string name, input int got_bursts, input int want_bursts);
    vectors++;
    if (got_bursts != want_bursts) begin
      miscompares++;
      $display("[TB] FAIL %s_bursts: got %0d, required %0d", name, got_bursts, want_bursts);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tuser !== '0 ||
        m_axis_tlast !== 1'b0 || cnt_col !== '0 || cnt_row !== '0 || sof_error !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: tready=%0b tvalid=%0b data=%h user=%b last=%0b col=%0d row=%0d err=%0b, required all 0",
               s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, cnt_col, cnt_row, sof_error);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int b0;
    b0 = bursts_rx;
    send_range(0, 25, 1, 0);
    vectors++;
    if (cnt_col !== 5 || cnt_row !== 1) begin
      miscompares++;
      $display("[TB] FAIL basic_midcnt: col=%0d row=%0d, required col=5 row=1", cnt_col, cnt_row);
    end
    send_range(25, TOTAL - 25, 0, 0);
    wait_drain("basic");
    check_counts("basic", bursts_rx - b0, 40);
    vectors++;
    if (cnt_col !== 0 || cnt_row !== 0 || sof_err_seen != 0) begin
      miscompares++;
      $display("[TB] FAIL basic_endcnt: col=%0d row=%0d errs=%0d, required 0 0 0", cnt_col, cnt_row, sof_err_seen);
    end
  endtask

  task automatic test_junk();
    int b0;
    b0 = bursts_rx;
    send_range(900, 5, 0, 0);
    send_range(0, TOTAL, 1, 0);
    wait_drain("junk");
    check_counts("junk", bursts_rx - b0, 40);
  endtask

  task automatic test_stall();
    int b0;
    b0 = bursts_rx;
    blocked_cycles = 0;
    send_range(0, 10, 1, 0);
    stall_cycles = 25;
    send_range(10, TOTAL - 10, 0, 0);
    wait_drain("stall");
    check_counts("stall", bursts_rx - b0, 40);
    vectors++;
    if (blocked_cycles != 16) begin
      miscompares++;
      $display("[TB] FAIL stall_tready_low: blocked %0d cycles, required 16", blocked_cycles);
    end
  endtask

  task automatic test_random();
    int b0;
    b0 = bursts_rx;
    rand_ready = 1;
    for (int f = 0; f < 3; f++) send_range(f * 7, TOTAL, 1, 1);
    rand_ready = 0;
    wait_drain("random");
    check_counts("random", bursts_rx - b0, 120);
  endtask

  task automatic test_sof_error();
    int b0, e0;
    b0 = bursts_rx;
    e0 = sof_err_seen;
    send_range(0, 137, 1, 0);
    send_range(137, TOTAL, 1, 0);
    wait_drain("soferr");
    check_counts("soferr", bursts_rx - b0, 13 + 40);
    vectors++;
    if (sof_err_seen - e0 != 1) begin
      miscompares++;
      $display("[TB] FAIL sof_error_pulse: %0d cycles high, required 1", sof_err_seen - e0);
    end
  endtask

  task automatic test_reset_midframe();
    int b0;
    send_range(0, 50, 1, 0);
    stall_cycles = 1000;
    send_range(50, 6, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (s_axis_tready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_tready: got %0b, required 0", s_axis_tready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tuser !== '0 || m_axis_tlast !== 1'b0 ||
        cnt_col !== '0 || cnt_row !== '0 || sof_error !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: tvalid=%0b data=%h user=%b col=%0d row=%0d, required all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tuser, cnt_col, cnt_row);
    end
    model_reset();
    stall_cycles = 0;
    reset = 1'b0;
    b0 = bursts_rx;
    send_range(300, TOTAL, 1, 0);
    wait_drain("midreset");
    check_counts("midreset", bursts_rx - b0, 40);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_junk();
    test_stall();
    test_random();
    test_sof_error();
    test_reset_midframe();
    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
